// File: rtl/comm_uart_tx_if.sv
// Signal bundle between the COMM backend buffers / RX echo path and the
// UART transmit stage. The transmitter uses the slave modport.
interface comm_uart_tx_if;
  logic       fesel;
  logic       echo_valid;
  logic [7:0] echo_data;
  logic       hmselbuf_xfer;
  logic [7:0] hmselbuf_data;
  logic       decerrbuf_xfer;
  logic [7:0] decerrbuf_data;
  logic       hrdatabuf_xfer;
  logic [7:0] hrdatabuf_data;
  logic       ahberrbuf_xfer;
  logic [7:0] ahberrbuf_data;
  logic       tx_work;
  logic       echo_out;
  logic       echo_ovf;
  logic       tx_busy;
  logic       txd;

  modport master (
    output fesel, echo_valid, echo_data,
           hmselbuf_xfer, hmselbuf_data, decerrbuf_xfer, decerrbuf_data,
           hrdatabuf_xfer, hrdatabuf_data, ahberrbuf_xfer, ahberrbuf_data,
    input  tx_work, echo_out, echo_ovf, tx_busy, txd
  );

  modport slave (
    input  fesel, echo_valid, echo_data,
           hmselbuf_xfer, hmselbuf_data, decerrbuf_xfer, decerrbuf_data,
           hrdatabuf_xfer, hrdatabuf_data, ahberrbuf_xfer, ahberrbuf_data,
    output tx_work, echo_out, echo_ovf, tx_busy, txd
  );
endinterface

// File: rtl/comm_uart_tx.sv
// UART transmit stage of the COMM controller: arbitrates the RX echo byte
// against the four backend buffer streams and serialises the winner as 8N1.
//
// state | meaning
// IDLE  | line high, arbitration open when fesel=0
// START | start bit (txd=0), BAUD_DIV cycles
// DATA  | 8 data bits LSB first, BAUD_DIV cycles each
// STOP  | stop bit (txd=1), BAUD_DIV cycles
module comm_uart_tx #(
  parameter  int BAUD_DIV = 16,
  localparam int DIV_W    = $clog2(BAUD_DIV)
) (
  input  logic          clk,
  input  logic          rstn,
  comm_uart_tx_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam logic [DIV_W-1:0] BAUD_LAST = DIV_W'(BAUD_DIV - 1);

  state_t           r_state;
  logic [DIV_W-1:0] r_baud_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_src_echo;
  logic             r_echo_pend;
  logic [7:0]       r_echo_data;
  logic             r_txd;
  logic             r_tx_work;
  logic             r_echo_out;
  logic             r_echo_ovf;
  logic             r_tx_busy;

  state_t           w_state_nxt;
  logic [DIV_W-1:0] w_baud_nxt;
  logic [2:0]       w_bit_nxt;
  logic [7:0]       w_shift_nxt;
  logic             w_src_echo_nxt;
  logic             w_baud_wrap;
  logic             w_arb_en;
  logic             w_echo_new;
  logic             w_load;
  logic             w_load_echo;
  logic [7:0]       w_load_data;
  logic             w_pend_loaded;
  logic             w_bypass;
  logic             w_capture;
  logic             w_drop;
  logic             w_pend_nxt;
  logic             w_txd_nxt;

  assign w_baud_wrap = (r_baud_cnt == BAUD_LAST);
  assign w_arb_en    = (r_state == S_IDLE) && !bus.fesel;
  assign w_echo_new  = bus.echo_valid && !bus.fesel;

  // Fixed-priority arbitration; a fresh echo with an empty holding register
  // goes straight to the shifter so it still beats a same-cycle backend byte.
  always_comb begin
    w_load      = 1'b0;
    w_load_echo = 1'b0;
    w_load_data = 8'h00;
    if (w_arb_en) begin
      if (r_echo_pend) begin
        w_load      = 1'b1;
        w_load_echo = 1'b1;
        w_load_data = r_echo_data;
      end else if (w_echo_new) begin
        w_load      = 1'b1;
        w_load_echo = 1'b1;
        w_load_data = bus.echo_data;
      end else if (bus.hmselbuf_xfer) begin
        w_load      = 1'b1;
        w_load_data = bus.hmselbuf_data;
      end else if (bus.decerrbuf_xfer) begin
        w_load      = 1'b1;
        w_load_data = bus.decerrbuf_data;
      end else if (bus.hrdatabuf_xfer) begin
        w_load      = 1'b1;
        w_load_data = bus.hrdatabuf_data;
      end else if (bus.ahberrbuf_xfer) begin
        w_load      = 1'b1;
        w_load_data = bus.ahberrbuf_data;
      end
    end
  end

  // Echo holding register bookkeeping: capture, same-cycle refill, or drop.
  always_comb begin
    w_pend_loaded = w_load_echo && r_echo_pend;
    w_bypass      = w_load_echo && !r_echo_pend;
    w_capture     = w_echo_new && !w_bypass && (!r_echo_pend || w_pend_loaded);
    w_drop        = w_echo_new && r_echo_pend && !w_pend_loaded;
    w_pend_nxt    = r_echo_pend;
    if (w_capture) begin
      w_pend_nxt = 1'b1;
    end else if (w_pend_loaded) begin
      w_pend_nxt = 1'b0;
    end
  end

  // Next-state and serialiser datapath.
  always_comb begin
    w_state_nxt    = r_state;
    w_baud_nxt     = r_baud_cnt;
    w_bit_nxt      = r_bit_cnt;
    w_shift_nxt    = r_shift;
    w_src_echo_nxt = r_src_echo;
    if (r_state != S_IDLE) begin
      w_baud_nxt = w_baud_wrap ? '0 : r_baud_cnt + DIV_W'(1);
    end
    case (r_state)
      S_IDLE: begin
        if (w_load) begin
          w_state_nxt    = S_START;
          w_baud_nxt     = '0;
          w_bit_nxt      = 3'd0;
          w_shift_nxt    = w_load_data;
          w_src_echo_nxt = w_load_echo;
        end
      end
      S_START: begin
        if (w_baud_wrap) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = 3'd0;
        end
      end
      S_DATA: begin
        if (w_baud_wrap) begin
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = S_STOP;
            w_bit_nxt   = 3'd0;
          end else begin
            w_bit_nxt = r_bit_cnt + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (w_baud_wrap) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Line level follows the state being entered so txd is a clean flop output.
  always_comb begin
    case (w_state_nxt)
      S_START: w_txd_nxt = 1'b0;
      S_DATA:  w_txd_nxt = w_shift_nxt[0];
      default: w_txd_nxt = 1'b1;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counters, shifter, echo holding register and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_baud_cnt  <= '0;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'h00;
      r_src_echo  <= 1'b0;
      r_echo_pend <= 1'b0;
      r_echo_data <= 8'h00;
      r_txd       <= 1'b1;
      r_tx_work   <= 1'b0;
      r_echo_out  <= 1'b0;
      r_echo_ovf  <= 1'b0;
      r_tx_busy   <= 1'b0;
    end else begin
      r_baud_cnt  <= w_baud_nxt;
      r_bit_cnt   <= w_bit_nxt;
      r_shift     <= w_shift_nxt;
      r_src_echo  <= w_src_echo_nxt;
      r_echo_pend <= w_pend_nxt;
      if (w_capture) begin
        r_echo_data <= bus.echo_data;
      end
      r_txd      <= w_txd_nxt;
      r_tx_work  <= w_load && !w_load_echo;
      r_echo_out <= w_pend_nxt || ((w_state_nxt != S_IDLE) && w_src_echo_nxt);
      r_echo_ovf <= w_drop;
      r_tx_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  assign bus.txd      = r_txd;
  assign bus.tx_work  = r_tx_work;
  assign bus.echo_out = r_echo_out;
  assign bus.echo_ovf = r_echo_ovf;
  assign bus.tx_busy  = r_tx_busy;

endmodule

// File: tb/tb_comm_uart_tx.sv
// Bench for comm_uart_tx: expected frames are queued when stimulus is issued;
// a line monitor decodes txd and compares each frame against the queue.
module tb_comm_uart_tx;
  localparam int BAUD  = 16;
  localparam int FRAME = 10 * BAUD;
  localparam int PER   = FRAME + 1;

  typedef struct packed {
    logic [7:0] data;
    logic       echo;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  comm_uart_tx_if u_if();

  comm_uart_tx #(.BAUD_DIV(BAUD)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (u_if)
  );

  exp_t       exp_q[$];
  int         start_times[$];
  int         tw_times[$];
  logic [7:0] bq0[$], bq1[$], bq2[$], bq3[$];
  int n_vec   = 0;
  int n_err   = 0;
  int cyc     = 0;
  int tw_cnt  = 0;
  int ovf_cnt = 0;
  bit tw_seen = 1'b0;
  bit mon_en  = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_echo(input logic [7:0] b, input bit expect_tx);
    u_if.echo_valid = 1'b1;
    u_if.echo_data  = b;
    if (expect_tx) exp_q.push_back({b, 1'b1});
    tick(1);
    u_if.echo_valid = 1'b0;
  endtask

  task automatic push_bk(input int s, input logic [7:0] b);
    case (s)
      0:       bq0.push_back(b);
      1:       bq1.push_back(b);
      2:       bq2.push_back(b);
      default: bq3.push_back(b);
    endcase
    exp_q.push_back({b, 1'b0});
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || u_if.tx_busy) && n < budget) begin
      tick(1);
      n++;
    end
    if (n >= budget) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d frames outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    tick(3);
  endtask

  // cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // pulse bookkeeping, sampled on the inactive edge
  always @(negedge clk) begin
    if (rstn) begin
      if (u_if.tx_work) begin
        tw_cnt++;
        tw_seen = 1'b1;
        tw_times.push_back(cyc);
      end
      if (u_if.echo_ovf) ovf_cnt++;
    end
  end

  // backend model: each buffer holds xfer while it has bytes; tx_work steps
  // the buffer the transmitter picked (highest priority one with data)
  initial begin : backend
    logic [7:0] junk;
    forever begin
      @(posedge clk);
      #2;
      if (tw_seen) begin
        tw_seen = 1'b0;
        if (bq0.size() != 0)      junk = bq0.pop_front();
        else if (bq1.size() != 0) junk = bq1.pop_front();
        else if (bq2.size() != 0) junk = bq2.pop_front();
        else if (bq3.size() != 0) junk = bq3.pop_front();
      end
      u_if.hmselbuf_xfer  = (bq0.size() != 0);
      u_if.hmselbuf_data  = (bq0.size() != 0) ? bq0[0] : 8'h00;
      u_if.decerrbuf_xfer = (bq1.size() != 0);
      u_if.decerrbuf_data = (bq1.size() != 0) ? bq1[0] : 8'h00;
      u_if.hrdatabuf_xfer = (bq2.size() != 0);
      u_if.hrdatabuf_data = (bq2.size() != 0) ? bq2[0] : 8'h00;
      u_if.ahberrbuf_xfer = (bq3.size() != 0);
      u_if.ahberrbuf_data = (bq3.size() != 0) ? bq3[0] : 8'h00;
    end
  end

  // line monitor: decode each 8N1 frame at mid-bit and score it
  initial begin : monitor
    exp_t       e;
    logic [7:0] got;
    logic       st, sp, tw, eo, bz;
    forever begin
      @(negedge clk);
      if (mon_en && rstn && u_if.txd === 1'b0) begin
        tw = u_if.tx_work;
        eo = u_if.echo_out;
        bz = u_if.tx_busy;
        start_times.push_back(cyc);
        repeat (BAUD / 2) @(negedge clk);
        st = u_if.txd;
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge clk);
          got[i] = u_if.txd;
        end
        repeat (BAUD) @(negedge clk);
        sp = u_if.txd;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_frame: got byte %02h, expected no frame", got);
        end else begin
          e = exp_q.pop_front();
          chk("frame_data", 32'(got), 32'(e.data));
          chk("start_bit", 32'(st), 32'd0);
          chk("stop_bit", 32'(sp), 32'd1);
          chk("tx_work_at_start", 32'(tw), 32'(!e.echo));
          chk("tx_busy_in_frame", 32'(bz), 32'd1);
          if (e.echo) chk("echo_out_in_echo_frame", 32'(eo), 32'd1);
        end
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] msg [10];
    int bad_txd, bad_busy, bad_pulse;
    int tw0, ovf0, fr0, idx, f_cyc, mask, nbk;
    logic [7:0] rb;

    u_if.fesel          = 1'b0;
    u_if.echo_valid     = 1'b0;
    u_if.echo_data      = 8'h00;
    u_if.hmselbuf_xfer  = 1'b0;
    u_if.hmselbuf_data  = 8'h00;
    u_if.decerrbuf_xfer = 1'b0;
    u_if.decerrbuf_data = 8'h00;
    u_if.hrdatabuf_xfer = 1'b0;
    u_if.hrdatabuf_data = 8'h00;
    u_if.ahberrbuf_xfer = 1'b0;
    u_if.ahberrbuf_data = 8'h00;
    tick(5);
    chk("reset_txd", 32'(u_if.txd), 32'd1);
    rstn = 1'b1;

    // idle after reset
    bad_txd = 0; bad_busy = 0; bad_pulse = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (u_if.txd !== 1'b1) bad_txd++;
      if (u_if.tx_busy !== 1'b0) bad_busy++;
      if (u_if.tx_work !== 1'b0 || u_if.echo_out !== 1'b0 || u_if.echo_ovf !== 1'b0) bad_pulse++;
    end
    chk("idle_txd_not_high_cycles", 32'(bad_txd), 32'd0);
    chk("idle_busy_cycles", 32'(bad_busy), 32'd0);
    chk("idle_pulse_cycles", 32'(bad_pulse), 32'd0);

    // single echo byte 'A'
    tw0 = tw_cnt;
    send_echo(8'h41, 1'b1);
    chk("echo_out_next_cycle", 32'(u_if.echo_out), 32'd1);
    drain(3 * FRAME);
    chk("echo_out_after_stop", 32'(u_if.echo_out), 32'd0);
    chk("echo_no_tx_work", 32'(tw_cnt - tw0), 32'd0);

    // hmsel buffer streaming a text line
    msg = '{8'h48, 8'h4D, 8'h53, 8'h45, 8'h4C, 8'h3A, 8'h20, 8'h31, 8'h0D, 8'h0A};
    tw_times.delete();
    tw0 = tw_cnt;
    for (int i = 0; i < 10; i++) push_bk(0, msg[i]);
    drain(12 * FRAME);
    chk("hmsel_tx_work_count", 32'(tw_cnt - tw0), 32'd10);
    for (int i = 1; i < tw_times.size(); i++)
      chk("hmsel_tx_work_period", 32'(tw_times[i] - tw_times[i-1]), 32'(PER));

    // echo and hrdata requested in the same idle cycle
    tw_times.delete();
    idx = start_times.size();
    rb = 8'($urandom);
    push_bk(2, 8'($urandom));
    send_echo(rb, 1'b1);
    exp_q.push_back(exp_q.pop_front());
    drain(4 * FRAME);
    if (tw_times.size() == 0 || start_times.size() <= idx) begin
      n_vec++; n_err++;
      $display("FAIL echo_vs_hrdata: tx_work or echo frame missing, expected both");
    end else begin
      chk("echo_then_hrdata_tx_work_offset", 32'(tw_times[0] - start_times[idx]), 32'(PER));
    end

    // two echoes 3 cycles apart, then a drop while the holding register is full
    ovf0 = ovf_cnt;
    send_echo(8'h5A, 1'b1);
    tick(2);
    send_echo(8'hC3, 1'b1);
    chk("second_echo_no_ovf", 32'(ovf_cnt - ovf0), 32'd0);
    tick(20);
    send_echo(8'h77, 1'b0);
    chk("drop_ovf_pulse", 32'(u_if.echo_ovf), 32'd1);
    tick(1);
    chk("drop_ovf_one_cycle", 32'(u_if.echo_ovf), 32'd0);
    drain(4 * FRAME);
    chk("drop_ovf_count", 32'(ovf_cnt - ovf0), 32'd1);

    // fesel raised mid-DATA of 0xA5 with a pending echo and ahberr byte
    tw0 = tw_cnt;
    ovf0 = ovf_cnt;
    fr0 = start_times.size();
    send_echo(8'hA5, 1'b1);
    tick(40);
    send_echo(8'h3C, 1'b1);
    u_if.fesel = 1'b1;
    push_bk(3, 8'($urandom));
    send_echo(8'hEE, 1'b0);
    tick(250);
    chk("fesel_frames_started", 32'(start_times.size() - fr0), 32'd1);
    chk("fesel_busy", 32'(u_if.tx_busy), 32'd0);
    chk("fesel_echo_retained", 32'(u_if.echo_out), 32'd1);
    chk("fesel_no_tx_work", 32'(tw_cnt - tw0), 32'd0);
    chk("fesel_no_ovf", 32'(ovf_cnt - ovf0), 32'd0);
    idx = start_times.size();
    tw_times.delete();
    f_cyc = cyc;
    u_if.fesel = 1'b0;
    drain(4 * FRAME);
    if (start_times.size() <= idx || tw_times.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL fesel_release: frames missing after release, expected echo then ahberr");
    end else begin
      chk("fesel_release_latency", 32'(start_times[idx] - f_cyc), 32'd1);
      chk("fesel_ahberr_after_echo", 32'(tw_times[0] - start_times[idx]), 32'(PER));
    end

    // randomized multi-source requests issued in one idle cycle
    for (int it = 0; it < 12; it++) begin
      mask = int'($urandom_range(1, 31));
      nbk = 0;
      tw0 = tw_cnt;
      rb = 8'($urandom);
      if (mask[0]) exp_q.push_back({rb, 1'b1});
      for (int s = 0; s < 4; s++) begin
        if (mask[s+1]) begin
          push_bk(s, 8'($urandom));
          nbk++;
        end
      end
      if (mask[0]) begin
        u_if.echo_valid = 1'b1;
        u_if.echo_data  = rb;
        tick(1);
        u_if.echo_valid = 1'b0;
      end else begin
        tick(1);
      end
      drain(6 * FRAME + 50);
      chk("rand_tx_work_count", 32'(tw_cnt - tw0), 32'(nbk));
    end

    // reset mid-frame
    mon_en = 1'b0;
    send_echo(8'h00, 1'b0);
    tick(50);
    chk("pre_reset_txd_low", 32'(u_if.txd), 32'd0);
    rstn = 1'b0;
    #1;
    chk("reset_txd_immediate", 32'(u_if.txd), 32'd1);
    chk("reset_busy", 32'(u_if.tx_busy), 32'd0);
    chk("reset_echo_out", 32'(u_if.echo_out), 32'd0);
    tick(3);
    rstn = 1'b1;
    tick(5);
    chk("post_reset_idle_txd", 32'(u_if.txd), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
